// File: rtl/alu_exe_issue_ctrl_if.sv
// Dispatch-side enqueue and execution-unit request bundle for the ALU issue controller.
// master drives enqueue and consumes requests; slave is the issue controller.
interface alu_exe_issue_ctrl_if;
  logic        enq_valid;
  logic        enq_ready;
  logic [9:0]  enq_uop_fu_code;
  logic [19:0] enq_uop_br_mask;
  logic [6:0]  enq_uop_rob_idx;
  logic [6:0]  enq_uop_pdst;
  logic [64:0] enq_rs1_data;
  logic [64:0] enq_rs2_data;

  logic        req_valid;
  logic [9:0]  req_fu_code;
  logic [19:0] req_br_mask;
  logic [6:0]  req_rob_idx;
  logic [6:0]  req_pdst;
  logic [64:0] req_rs1_data;
  logic [64:0] req_rs2_data;

  modport master (
    output enq_valid,
    output enq_uop_fu_code,
    output enq_uop_br_mask,
    output enq_uop_rob_idx,
    output enq_uop_pdst,
    output enq_rs1_data,
    output enq_rs2_data,
    input  enq_ready,
    input  req_valid,
    input  req_fu_code,
    input  req_br_mask,
    input  req_rob_idx,
    input  req_pdst,
    input  req_rs1_data,
    input  req_rs2_data
  );

  modport slave (
    input  enq_valid,
    input  enq_uop_fu_code,
    input  enq_uop_br_mask,
    input  enq_uop_rob_idx,
    input  enq_uop_pdst,
    input  enq_rs1_data,
    input  enq_rs2_data,
    output enq_ready,
    output req_valid,
    output req_fu_code,
    output req_br_mask,
    output req_rob_idx,
    output req_pdst,
    output req_rs1_data,
    output req_rs2_data
  );
endinterface

// File: rtl/alu_exe_issue_ctrl.sv
// In-order ALU/MUL issue queue with writeback-slot reservation and branch kill.
// Define ALU_ISSUE_PERF_EN to build the saturating stall_cycles counter.
module alu_exe_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  alu_exe_issue_ctrl_if.slave    io,
  input  logic [19:0]            io_brupdate_b1_resolve_mask,
  input  logic [19:0]            io_brupdate_b1_mispredict_mask,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [31:0]            stall_cycles
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] C_FULL = (PW+1)'(DEPTH);
  localparam logic [MUL_LAT:0] C_MUL_BIT = (MUL_LAT+1)'(1) << MUL_LAT;
  localparam logic [MUL_LAT:0] C_ALU_BIT = (MUL_LAT+1)'(1) << ALU_LAT;

  logic [DEPTH-1:0] r_vld;
  logic [9:0]       r_fu   [DEPTH];
  logic [19:0]      r_br   [DEPTH];
  logic [6:0]       r_rob  [DEPTH];
  logic [6:0]       r_pdst [DEPTH];
  logic [64:0]      r_rs1  [DEPTH];
  logic [64:0]      r_rs2  [DEPTH];

  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [PW:0]      r_count;
  logic [MUL_LAT:0] r_wb_busy;

  logic             r_req_valid;
  logic [9:0]       r_req_fu;
  logic [19:0]      r_req_br;
  logic [6:0]       r_req_rob;
  logic [6:0]       r_req_pdst;
  logic [64:0]      r_req_rs1;
  logic [64:0]      r_req_rs2;

  logic [19:0]      w_res;
  logic [19:0]      w_mis;
  logic             w_enq_ready;
  logic             w_enq_fire;
  logic             w_enq_kill;
  logic             w_nonempty;
  logic [19:0]      w_head_br;
  logic             w_head_mul;
  logic             w_head_live;
  logic             w_drop;
  logic             w_issuable;
  logic             w_slot_busy;
  logic             w_issue;
  logic             w_pop;
  logic [MUL_LAT:0] w_claim;
  logic [MUL_LAT:0] w_wb_nxt;
  logic [PW:0]      w_count_nxt;
  logic [DEPTH-1:0] w_kill_vec;
  logic [DEPTH-1:0] w_vld_nxt;

  assign w_res = io_brupdate_b1_resolve_mask;
  assign w_mis = io_brupdate_b1_mispredict_mask;

  // Ready looks only at the registered count; a pop this cycle frees nothing.
  assign w_enq_ready = (r_count != C_FULL);
  assign w_enq_fire  = io.enq_valid & w_enq_ready;
  assign w_enq_kill  = |(io.enq_uop_br_mask & w_mis);

  assign w_nonempty  = (r_count != '0);
  assign w_head_br   = r_br[r_head];
  assign w_head_mul  = r_fu[r_head][3];
  assign w_head_live = w_nonempty & r_vld[r_head];
  assign w_drop      = w_nonempty & ~r_vld[r_head];
  assign w_issuable  = w_head_live & ~|(w_head_br & w_mis);

  assign w_slot_busy = w_head_mul ? r_wb_busy[MUL_LAT]
                                  : r_wb_busy[ALU_LAT];
  assign w_issue     = w_issuable & ~w_slot_busy;
  assign w_pop       = w_issue | w_drop;

  assign w_claim     = w_head_mul ? C_MUL_BIT : C_ALU_BIT;
  assign w_wb_nxt    = (w_issue ? (r_wb_busy | w_claim)
                                : r_wb_busy) >> 1;

  assign w_count_nxt = r_count
                     + (PW+1)'(w_enq_fire)
                     - (PW+1)'(w_pop);

  always_comb begin
    w_kill_vec = '0;
    w_vld_nxt  = r_vld;
    for (int i = 0; i < DEPTH; i++) begin
      w_kill_vec[i] = |(r_br[i] & w_mis);
      if (w_kill_vec[i]) begin
        w_vld_nxt[i] = 1'b0;
      end
    end
    if (w_enq_fire) begin
      w_vld_nxt[r_tail] = ~w_enq_kill;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_vld       <= '0;
      r_wb_busy   <= '0;
      r_req_valid <= 1'b0;
      r_req_fu    <= '0;
      r_req_br    <= '0;
      r_req_rob   <= '0;
      r_req_pdst  <= '0;
      r_req_rs1   <= '0;
      r_req_rs2   <= '0;
    end else begin
      r_head      <= r_head + PW'(w_pop);
      r_tail      <= r_tail + PW'(w_enq_fire);
      r_count     <= w_count_nxt;
      r_vld       <= w_vld_nxt;
      r_wb_busy   <= w_wb_nxt;
      r_req_valid <= w_issue;
      if (w_issue) begin
        r_req_fu   <= r_fu[r_head];
        r_req_br   <= w_head_br & ~w_res;
        r_req_rob  <= r_rob[r_head];
        r_req_pdst <= r_pdst[r_head];
        r_req_rs1  <= r_rs1[r_head];
        r_req_rs2  <= r_rs2[r_head];
      end
    end
  end

  // Payload needs no reset: liveness is carried entirely by r_vld and r_count.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_kill_vec[i]) begin
        r_br[i] <= r_br[i] & ~w_res;
      end
    end
    if (w_enq_fire) begin
      r_fu[r_tail]   <= io.enq_uop_fu_code;
      r_br[r_tail]   <= io.enq_uop_br_mask & ~w_res;
      r_rob[r_tail]  <= io.enq_uop_rob_idx;
      r_pdst[r_tail] <= io.enq_uop_pdst;
      r_rs1[r_tail]  <= io.enq_rs1_data;
      r_rs2[r_tail]  <= io.enq_rs2_data;
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  logic        w_stall;
  logic [31:0] r_stall;

  assign w_stall = w_issuable & w_slot_busy;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_stall <= '0;
    end else if (w_stall && (r_stall != '1)) begin
      r_stall <= r_stall + 32'd1;
    end
  end

  assign stall_cycles = r_stall;
`else
  assign stall_cycles = '0;
`endif

  assign io.enq_ready    = w_enq_ready;
  assign io.req_valid    = r_req_valid;
  assign io.req_fu_code  = r_req_fu;
  assign io.req_br_mask  = r_req_br;
  assign io.req_rob_idx  = r_req_rob;
  assign io.req_pdst     = r_req_pdst;
  assign io.req_rs1_data = r_req_rs1;
  assign io.req_rs2_data = r_req_rs2;
  assign occupancy       = r_count;
endmodule

// File: tb/tb_alu_exe_issue_ctrl.sv
// Directed bench for alu_exe_issue_ctrl with a queue/claim-set reference model.
// The model tracks absolute writeback cycles claimed rather than a shift vector.
module tb_alu_exe_issue_ctrl;
  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 1;
  localparam int MUL_LAT = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [19:0] res   = '0;
  logic [19:0] mis   = '0;
  logic [2:0]  occupancy;
  logic [31:0] stall_cycles;

  alu_exe_issue_ctrl_if bus ();

  alu_exe_issue_ctrl #(
    .DEPTH  (DEPTH),
    .ALU_LAT(ALU_LAT),
    .MUL_LAT(MUL_LAT)
  ) dut (
    .clock                         (clock),
    .reset                         (reset),
    .io                            (bus),
    .io_brupdate_b1_resolve_mask   (res),
    .io_brupdate_b1_mispredict_mask(mis),
    .occupancy                     (occupancy),
    .stall_cycles                  (stall_cycles)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [64:0] act,
                     input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit        v;
    bit [9:0]  fu;
    bit [19:0] br;
    bit [6:0]  rob;
    bit [6:0]  pdst;
    bit [64:0] rs1;
    bit [64:0] rs2;
  } uop_t;

  uop_t        mq[$];
  bit          claim[longint];
  longint      cyc    = 0;
  bit          m_init = 0;
  bit          e_rv   = 0;
  uop_t        e_req;
  int unsigned e_stall = 0;
  bit          saw7   = 0;
  bit          saw_full = 0;

  // Reference model plus per-cycle compare; inputs seen here are the ones
  // that were stable across the preceding rising edge.
  always @(negedge clock) begin
    bit     full;
    bit     issued;
    int     lat;
    uop_t   nu;
    full   = 0;
    issued = 0;
    lat    = 0;
    if (!reset) begin
      mq.delete();
      claim.delete();
      e_rv    = 0;
      e_req   = '{default: '0};
      e_stall = 0;
      m_init  = 1;
    end else if (m_init) begin
      full = (mq.size() == DEPTH);
      if (mq.size() > 0) begin
        if (!mq[0].v) begin
          void'(mq.pop_front());
        end else if ((mq[0].br & mis) == 0) begin
          lat = mq[0].fu[3] ? MUL_LAT : ALU_LAT;
          if (!claim.exists(cyc + lat)) begin
            claim[cyc + lat] = 1;
            issued    = 1;
            e_req     = mq[0];
            e_req.br  = mq[0].br & ~res;
            void'(mq.pop_front());
          end else begin
`ifdef ALU_ISSUE_PERF_EN
            if (e_stall != 32'hFFFF_FFFF) e_stall++;
`endif
          end
        end
      end
      e_rv = issued;
      foreach (mq[i]) begin
        if ((mq[i].br & mis) != 0) mq[i].v = 0;
        else mq[i].br = mq[i].br & ~res;
      end
      if (bus.enq_valid && !full) begin
        nu.v    = ((bus.enq_uop_br_mask & mis) == 0);
        nu.fu   = bus.enq_uop_fu_code;
        nu.br   = bus.enq_uop_br_mask & ~res;
        nu.rob  = bus.enq_uop_rob_idx;
        nu.pdst = bus.enq_uop_pdst;
        nu.rs1  = bus.enq_rs1_data;
        nu.rs2  = bus.enq_rs2_data;
        mq.push_back(nu);
      end
    end
    cyc++;
    if (m_init) begin
      chk("req_valid", 65'(bus.req_valid), 65'(e_rv));
      chk("req_fu_code", 65'(bus.req_fu_code), 65'(e_req.fu));
      chk("req_br_mask", 65'(bus.req_br_mask), 65'(e_req.br));
      chk("req_rob_idx", 65'(bus.req_rob_idx), 65'(e_req.rob));
      chk("req_pdst", 65'(bus.req_pdst), 65'(e_req.pdst));
      chk("req_rs1", bus.req_rs1_data, e_req.rs1);
      chk("req_rs2", bus.req_rs2_data, e_req.rs2);
      chk("occupancy", 65'(occupancy), 65'(mq.size()));
      chk("enq_ready", 65'(bus.enq_ready), 65'(mq.size() != DEPTH));
      chk("stall_cycles", 65'(stall_cycles), 65'(e_stall));
      if (bus.req_valid && bus.req_rob_idx == 7'd7) saw7 = 1;
      if (occupancy == 3'd4 && !bus.enq_ready) saw_full = 1;
    end
  end

  task automatic tick;
    @(negedge clock);
    #1;
  endtask

  task automatic idle;
    bus.enq_valid = 1'b0;
    tick();
  endtask

  // Holds the offer until a rising edge sees enq_ready high.
  task automatic offer(input logic [9:0] fu, input logic [19:0] br,
                       input logic [6:0] rob);
    bit acc;
    acc = 0;
    bus.enq_valid       = 1'b1;
    bus.enq_uop_fu_code = fu;
    bus.enq_uop_br_mask = br;
    bus.enq_uop_rob_idx = rob;
    bus.enq_uop_pdst    = rob ^ 7'h55;
    bus.enq_rs1_data    = {58'h3_0000_1234_5678, rob};
    bus.enq_rs2_data    = {rob, 58'h2_abcd_0000_0011};
    for (int i = 0; i < 40; i++) begin
      acc = bus.enq_ready;
      tick();
      if (acc) break;
    end
    if (!acc) chk("enq_accept_timeout", 65'(acc), 65'(1));
    bus.enq_valid = 1'b0;
  endtask

  int unsigned s0;
  int unsigned exp_stall;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.enq_valid       = 1'b0;
    bus.enq_uop_fu_code = '0;
    bus.enq_uop_br_mask = '0;
    bus.enq_uop_rob_idx = '0;
    bus.enq_uop_pdst    = '0;
    bus.enq_rs1_data    = '0;
    bus.enq_rs2_data    = '0;
    tick();
    tick();
    chk("rst_occupancy", 65'(occupancy), 65'(0));
    chk("rst_enq_ready", 65'(bus.enq_ready), 65'(1));
    chk("rst_req_valid", 65'(bus.req_valid), 65'(0));
    chk("rst_req_rs1", bus.req_rs1_data, 65'(0));
    reset = 1'b1;
    idle();

    // single ALU uop
    offer(10'h1, 20'h0, 7'd5);
    chk("t1_occ_after_enq", 65'(occupancy), 65'(1));
    chk("t1_rv_after_enq", 65'(bus.req_valid), 65'(0));
    idle();
    chk("t1_rv", 65'(bus.req_valid), 65'(1));
    chk("t1_rob", 65'(bus.req_rob_idx), 65'(5));
    chk("t1_occ", 65'(occupancy), 65'(0));
    idle();
    chk("t1_rv_drop", 65'(bus.req_valid), 65'(0));
    idle();

    // MUL then ALU two cycles later collides on the write port
    s0 = stall_cycles;
    offer(10'h8, 20'h0, 7'd10);
    idle();
    chk("t2_mul_rv", 65'(bus.req_valid), 65'(1));
    chk("t2_mul_rob", 65'(bus.req_rob_idx), 65'(10));
    offer(10'h1, 20'h0, 7'd11);
    chk("t2_enq_rv", 65'(bus.req_valid), 65'(0));
    idle();
    chk("t2_stall_rv", 65'(bus.req_valid), 65'(0));
    idle();
    chk("t2_alu_rv", 65'(bus.req_valid), 65'(1));
    chk("t2_alu_rob", 65'(bus.req_rob_idx), 65'(11));
`ifdef ALU_ISSUE_PERF_EN
    exp_stall = 1;
`else
    exp_stall = 0;
`endif
    chk("t2_stall_delta", 65'(stall_cycles - s0), 65'(exp_stall));
    repeat (4) idle();

    // resolve at issue trims the request mask
    offer(10'h1, 20'h6, 7'd20);
    res = 20'h2;
    idle();
    res = 20'h0;
    chk("t3_rv", 65'(bus.req_valid), 65'(1));
    chk("t3_br", 65'(bus.req_br_mask), 65'(20'h4));
    chk("t3_rob", 65'(bus.req_rob_idx), 65'(20));
    repeat (2) idle();

    // mispredict kills a queued uop; the follower still issues
    offer(10'h1, 20'h4, 7'd7);
    mis = 20'h4;
    offer(10'h1, 20'h0, 7'd8);
    mis = 20'h0;
    idle();
    chk("t4_drop_rv", 65'(bus.req_valid), 65'(0));
    idle();
    chk("t4_next_rv", 65'(bus.req_valid), 65'(1));
    chk("t4_next_rob", 65'(bus.req_rob_idx), 65'(8));
    chk("t4_killed_never_issued", 65'(saw7), 65'(0));
    repeat (4) idle();

    // M,M,A pattern outpaces issue and fills the queue
    for (int k = 0; k < 4; k++) begin
      offer(10'h8, 20'h0, 7'(40 + 3 * k));
      offer(10'h8, 20'h0, 7'(41 + 3 * k));
      offer(10'h1, 20'h0, 7'(42 + 3 * k));
    end
    repeat (20) idle();
    chk("t5_saw_full", 65'(saw_full), 65'(1));
    chk("t5_drained", 65'(occupancy), 65'(0));

    // reset with uops queued and MUL claims outstanding
    offer(10'h8, 20'h0, 7'd30);
    offer(10'h8, 20'h0, 7'd31);
    offer(10'h1, 20'h0, 7'd32);
    offer(10'h1, 20'h0, 7'd33);
    offer(10'h1, 20'h0, 7'd34);
    chk("t6_pre_occ", 65'(occupancy), 65'(3));
    reset = 1'b0;
    idle();
    reset = 1'b1;
    chk("t6_occ", 65'(occupancy), 65'(0));
    chk("t6_rv", 65'(bus.req_valid), 65'(0));
    chk("t6_stall", 65'(stall_cycles), 65'(0));
    offer(10'h1, 20'h0, 7'd50);
    chk("t6_enq_rv", 65'(bus.req_valid), 65'(0));
    idle();
    chk("t6_fresh_rv", 65'(bus.req_valid), 65'(1));
    chk("t6_fresh_rob", 65'(bus.req_rob_idx), 65'(50));
    chk("t6_fresh_stall", 65'(stall_cycles), 65'(0));
    repeat (3) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_exe_issue_ctrl.md
# alu_exe_issue_ctrl

Request-side initiator for the ALU/multiply execution unit. It buffers dispatched integer uops in a small in-order queue and issues at most one request per cycle onto the execution unit's `io_req_*` interface. It tracks a writeback-slot reservation vector so that an ALU result and a pipelined-multiply result never reach the single integer write port in the same cycle. It also applies branch resolve/mispredict updates to queued uops.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `ALU_LAT`, 1: cycles from `req_valid` to ALU writeback.
- `MUL_LAT`, 3: cycles from `req_valid` to multiply writeback; must exceed `ALU_LAT`.

Ports (clock and reset first):
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `enq_valid` in 1: dispatch offers a uop.
- `enq_ready` out 1: queue can accept.
- `enq_uop_fu_code` in 10: functional-unit code. Bit 3 means MUL; anything else is treated as ALU.
- `enq_uop_br_mask` in 20: branch dependency mask.
- `enq_uop_rob_idx` in 7, `enq_uop_pdst` in 7: uop tags.
- `enq_rs1_data` in 65, `enq_rs2_data` in 65: operands.
- `io_brupdate_b1_resolve_mask` in 20, `io_brupdate_b1_mispredict_mask` in 20: branch update.
- `req_valid` out 1: request to the execution unit.
- `req_fu_code` out 10, `req_br_mask` out 20, `req_rob_idx` out 7, `req_pdst` out 7, `req_rs1_data` out 65, `req_rs2_data` out 65: request fields.
- `occupancy` out log2(DEPTH)+1: live entry count.
- `stall_cycles` out 32: writeback-conflict stall counter.

## Operation
- Queue
  - Circular buffer with head/tail pointers and a count. Both pointers wrap modulo `DEPTH`.
  - `enq_ready = (count != DEPTH)`. It depends only on the registered count; a same-cycle pop does not free a slot for enqueue.
- Enqueue (`enq_valid & enq_ready`)
  - If `enq_uop_br_mask & mispredict_mask` ≠ 0: the handshake completes but the entry is written with valid=0.
  - Otherwise the stored mask is `enq_uop_br_mask & ~resolve_mask`.
- Branch update, every cycle, every queued entry:
  - `br_mask & mispredict_mask` ≠ 0: clear the entry's valid bit.
  - Otherwise: `br_mask &= ~resolve_mask`.
- Head handling:
  - An invalid (killed) head entry is popped without issue, one per cycle.
  - A valid head entry is issuable only if it is not killed by this cycle's mispredict mask.
- Writeback reservation:
  - Vector `wb_busy[MUL_LAT:0]`; bit k means the write port is claimed k cycles from now.
  - Issue class is MUL if `fu_code[3]`, else ALU. Let L be `MUL_LAT` or `ALU_LAT` accordingly.
  - Issue is allowed iff the head is issuable and `wb_busy[L] == 0`.
  - On issue: `wb_busy' = (wb_busy | 1<<L) >> 1`. Otherwise: `wb_busy' = wb_busy >> 1`.
- Issue:
  - Head is popped and copied into the request output register.
  - The registered `req_br_mask` is the head mask `& ~resolve_mask` of the issue cycle.
  - `req_valid` is 1 the following cycle only.
  - Once issued, the request is never retracted; the execution unit applies its own kill.
- Stall:
  - A cycle with an issuable head but a busy slot is a stall.
  - The head stays in place and is re-evaluated next cycle.
- `occupancy` counts entries between head and tail, killed ones included.

## Timing
- Reset (`reset == 0` at a clock edge):
  - Pointers, count, all entry valid bits and `wb_busy` go to 0.
  - `req_valid` = 0, `enq_ready` = 1, `occupancy` = 0, `stall_cycles` = 0.
  - `req_*` data fields = 0.
- Reset asserted mid-operation discards all queued uops and reservations. No request issues in the cycle after reset.
- Latency: a uop enqueued at edge t into an empty queue with a free slot is issued at t+1; `req_valid` is high during cycle t+1→t+2.
- Throughput: one issue per cycle.
- Example: an ALU issue in the cycle after a MUL issue made `MUL_LAT - ALU_LAT` cycles earlier stalls exactly one cycle.
- With a full queue, simultaneous enqueue and pop: the enqueue is refused and the pop proceeds.
- Pointer wrap from `DEPTH-1` to 0 needs no bubble.

## Configuration
- `ALU_ISSUE_PERF_EN` defined:
  - `stall_cycles` increments by 1 each stall cycle.
  - It saturates at 2^32−1 and clears on reset.
- Not defined: `stall_cycles` is tied to 0 and the counter logic is absent. Issue behaviour is identical in both builds.

## Test plan
- Single ALU uop (fu_code 10'h1, rob_idx 5) into an empty queue → `req_valid` exactly one cycle later with rob_idx 5, and `occupancy` returns to 0.
- MUL (fu_code 10'h8) issued at cycle t, ALU at head at cycle t+2 → with `MUL_LAT=3`, `ALU_LAT=1` the ALU stalls at t+2 and issues at t+3; `stall_cycles` = 1 with the macro, 0 without.
- Enqueue 4 uops with no issue possible (continuous MUL slot conflicts) → `enq_ready` = 0 at `occupancy` 4; the 5th offer is not accepted until a pop.
- Queued uop with br_mask 20'h4, `mispredict_mask` 20'h4 pulsed → entry dropped without `req_valid`; the next uop issues one cycle later.
- Queued uop with br_mask 20'h6, `resolve_mask` 20'h2 → issued `req_br_mask` = 20'h4.
- `reset` driven low while 3 uops are queued and a MUL slot is reserved → next cycle `occupancy` 0, `req_valid` 0, and a fresh ALU uop issues with no stall.
